approx_mult_seq: RTL and testbench

- Parametrised, handshaked, multi-cycle signed multiplier for the approximate CMAC datapath.
- Splits both WIDTH-bit two's-complement operands into CHUNK-bit magnitude slices and accumulates one CHUNK x CHUNK partial product per cycle.
- Optional approximation mode drops low-significance partial products to trade accuracy for energy.
- Sits between the CMAC operand fetch and the accumulator; produces an exact 2*WIDTH-bit two's-complement product when approximation is off, including the most-negative operand case.

---
 rtl/approx_mult_seq_if.sv | 25 ++
 rtl/approx_mult_seq.sv | 121 ++++++++++++
 tb/tb_approx_mult_seq.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_mult_seq_if.sv
// Operand/product handshake bundle for the sequential approximate multiplier.
interface approx_mult_seq_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_approx;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_prod;

  // Operand fetch / accumulator side.
  modport master (
    output in_valid, in_a, in_b, in_approx, out_ready,
    input  in_ready, out_valid, out_prod
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in_a, in_b, in_approx, out_ready,
    output in_ready, out_valid, out_prod
  );
endinterface

// File: rtl/approx_mult_seq.sv
// Multi-cycle signed multiplier: sign-magnitude split, one CHUNK x CHUNK
// partial product accumulated per cycle, optional dropping of low-order
// partial products in approximation mode.
module approx_mult_seq #(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 8,
  parameter int APPROX_LVL = 1
) (
  input  logic           nvdla_core_clk,
  input  logic           nvdla_core_rst,
  approx_mult_seq_if.slave bus
);

  localparam int NS = WIDTH / CHUNK;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int CW = 2 * CHUNK;
  localparam logic [IW-1:0] LAST = IW'(NS - 1);
  localparam logic [IW:0]   LVL  = (IW + 1)'(APPROX_LVL);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic            sign;
  logic            approx;
  logic [PW-1:0]   acc;
  // Slice indices i (of |a|) and j (of |b|); together they walk k = i*NS + j.
  logic [IW-1:0]   i_idx;
  logic [IW-1:0]   j_idx;
  logic            in_ready;
  logic            out_valid;
  logic [PW-1:0]   out_prod;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CW-1:0]    pp;
  logic [IW:0]      ij_sum;
  logic [PW-1:0]    term;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_prod  = out_prod;

  // Operand magnitudes and the current shifted (or dropped) partial product.
  always_comb begin
    abs_a   = bus.in_a[WIDTH-1] ? (~bus.in_a + 1'b1) : bus.in_a;
    abs_b   = bus.in_b[WIDTH-1] ? (~bus.in_b + 1'b1) : bus.in_b;
    a_slice = mag_a[i_idx*CHUNK +: CHUNK];
    b_slice = mag_b[j_idx*CHUNK +: CHUNK];
    pp      = CW'(a_slice) * CW'(b_slice);
    ij_sum  = {1'b0, i_idx} + {1'b0, j_idx};
    term    = PW'(pp) << (ij_sum * CHUNK);
    if (approx && (ij_sum < LVL)) begin
      term = '0;
    end
  end

  // Control FSM with registered handshake outputs and datapath state.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state     <= IDLE;
      mag_a     <= '0;
      mag_b     <= '0;
      sign      <= 1'b0;
      approx    <= 1'b0;
      acc       <= '0;
      i_idx     <= '0;
      j_idx     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_prod  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            sign     <= bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
            approx   <= bus.in_approx;
            acc      <= '0;
            i_idx    <= '0;
            j_idx    <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          acc <= acc + term;
          if (j_idx == LAST) begin
            j_idx <= '0;
            if (i_idx == LAST) begin
              state <= SIGN;
            end else begin
              i_idx <= i_idx + 1'b1;
            end
          end else begin
            j_idx <= j_idx + 1'b1;
          end
        end
        SIGN: begin
          out_prod  <= sign ? (~acc + 1'b1) : acc;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mult_seq.sv
// Scoreboard bench for approx_mult_seq: 16-bit default instance plus a
// 32-bit instance, directed vectors and randomized vectors against a
// plain-arithmetic reference model.
module tb_approx_mult_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  approx_mult_seq_if #(.WIDTH(16)) bus16 ();
  approx_mult_seq_if #(.WIDTH(32)) bus32 ();

  approx_mult_seq #(.WIDTH(16), .CHUNK(8), .APPROX_LVL(1)) dut16 (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .bus(bus16.slave)
  );

  approx_mult_seq #(.WIDTH(32), .CHUNK(8), .APPROX_LVL(3)) dut32 (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .bus(bus32.slave)
  );

  typedef struct {
    logic [63:0] prod;
    int          acc_cyc;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int ready_mode  = 0;  // 0: always ready, 1: random, 2: stalled

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact signed product; in approx mode the partial products
  // whose combined slice index is below lvl are subtracted back out.
  function automatic logic [63:0] model(input longint a, input longint b, input bit ap,
                                        input int w, input int ch, input int lvl);
    longint unsigned ma, mb, p, m;
    int ns;
    ma = (a < 0) ? -a : a;
    mb = (b < 0) ? -b : b;
    p  = ma * mb;
    if (ap) begin
      ns = w / ch;
      m  = (64'd1 << ch) - 1;
      for (int i = 0; i < ns; i++)
        for (int j = 0; j < ns; j++)
          if (i + j < lvl)
            p -= (((ma >> (i*ch)) & m) * ((mb >> (j*ch)) & m)) << ((i + j) * ch);
    end
    if ((a < 0) != (b < 0)) p = -p;
    if (2*w < 64) p &= (64'd1 << (2*w)) - 1;
    return p;
  endfunction

  // out_ready driver for the 16-bit instance.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus16.out_ready = 1'b1;
      1:       bus16.out_ready = 1'($urandom_range(0, 1));
      default: bus16.out_ready = 1'b0;
    endcase
  end

  // Monitor for the 16-bit instance: first sight of a product pops the
  // scoreboard; while stalled the product must stay put.
  logic        seen16 = 1'b0;
  logic [31:0] held16;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen16 = 1'b0;
    end else if (bus16.out_valid) begin
      if (!seen16) begin
        if (q16.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected16: got product 0x%0h, required no output", bus16.out_prod);
        end else begin
          e = q16.pop_front();
          check("prod16", 64'(bus16.out_prod), e.prod);
          check("latency16", 64'(cyc - e.acc_cyc), 64'd5);
        end
        seen16 = 1'b1;
        held16 = bus16.out_prod;
      end else begin
        check("hold16", 64'(bus16.out_prod), 64'(held16));
      end
      if (bus16.out_ready) seen16 = 1'b0;
    end
  end

  // Monitor for the 32-bit instance (always ready).
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus32.out_valid) begin
      if (q32.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected32: got product 0x%0h, required no output", bus32.out_prod);
      end else begin
        e = q32.pop_front();
        check("prod32", bus32.out_prod, e.prod);
        check("latency32", 64'(cyc - e.acc_cyc), 64'd17);
      end
    end
  end

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input bit ap,
                        input logic [31:0] expv);
    int n = 0;
    @(posedge clk); #1;
    bus16.in_a = a; bus16.in_b = b; bus16.in_approx = ap; bus16.in_valid = 1'b1;
    @(negedge clk);
    while (!bus16.in_ready && n < 200) begin n++; @(negedge clk); end
    if (!bus16.in_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept16: in_ready stayed 0, required 1");
    end else begin
      q16.push_back('{prod: 64'(expv), acc_cyc: cyc + 1});
    end
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input bit ap,
                        input logic [63:0] expv);
    int n = 0;
    @(posedge clk); #1;
    bus32.in_a = a; bus32.in_b = b; bus32.in_approx = ap; bus32.in_valid = 1'b1;
    @(negedge clk);
    while (!bus32.in_ready && n < 200) begin n++; @(negedge clk); end
    if (!bus32.in_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept32: in_ready stayed 0, required 1");
    end else begin
      q32.push_back('{prod: expv, acc_cyc: cyc + 1});
    end
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
  endtask

  task automatic drain16();
    int n = 0;
    @(negedge clk);
    while ((q16.size() != 0 || bus16.out_valid) && n < 1000) begin n++; @(negedge clk); end
    if (q16.size() != 0 || bus16.out_valid) begin
      vectors++; miscompares++;
      $display("FAIL drain16: %0d products outstanding, required 0", q16.size());
    end
  endtask

  task automatic drain32();
    int n = 0;
    @(negedge clk);
    while ((q32.size() != 0 || bus32.out_valid) && n < 1000) begin n++; @(negedge clk); end
    if (q32.size() != 0 || bus32.out_valid) begin
      vectors++; miscompares++;
      $display("FAIL drain32: %0d products outstanding, required 0", q32.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra, rb;
    logic [31:0] wa, wb;
    bit          ap;
    int          n;

    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_approx = 1'b0;
    bus32.in_valid = 1'b0; bus32.in_a = '0; bus32.in_b = '0; bus32.in_approx = 1'b0;
    bus32.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus16.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus16.out_valid), 64'd0);
    check("rst_out_prod", 64'(bus16.out_prod), 64'd0);
    check("rst_in_ready32", 64'(bus32.in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed, exact and approximate.
    send16(16'h7FFF, 16'h7FFF, 1'b0, 32'h3FFF0001);
    send16(16'hFFFF, 16'h0002, 1'b0, 32'hFFFFFFFE);
    send16(16'h8000, 16'h8000, 1'b0, 32'h40000000);
    send16(16'h8000, 16'h0001, 1'b0, 32'hFFFF8000);
    send16(16'h0000, 16'h8001, 1'b0, 32'h00000000);
    send16(16'h0101, 16'h0101, 1'b1, 32'h00010200);
    send16(16'h00FF, 16'h00FF, 1'b1, 32'h00000000);
    send16(16'hFEFF, 16'h0101, 1'b1, 32'hFFFEFE00);
    send16(16'h0101, 16'h0101, 1'b0, 32'h00010201);
    drain16();

    // Backpressure: product stalls, new operands must be ignored.
    ready_mode = 2;
    send16(16'h1234, 16'h0010, 1'b0, 32'h00012340);
    n = 0;
    @(negedge clk);
    while (!bus16.out_valid && n < 100) begin n++; @(negedge clk); end
    check("bp_out_valid", 64'(bus16.out_valid), 64'd1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      bus16.in_a = 16'h5555; bus16.in_b = 16'h3333; bus16.in_approx = 1'b0; bus16.in_valid = 1'b1;
      @(negedge clk);
      check("bp_in_ready", 64'(bus16.in_ready), 64'd0);
      check("bp_valid_held", 64'(bus16.out_valid), 64'd1);
    end
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    ready_mode = 0;
    n = 0;
    @(negedge clk);
    while (!(bus16.out_valid && bus16.out_ready) && n < 20) begin n++; @(negedge clk); end
    @(negedge clk);
    check("bp_release_ready", 64'(bus16.in_ready), 64'd1);
    check("bp_release_valid", 64'(bus16.out_valid), 64'd0);
    send16(16'h0007, 16'hFFFD, 1'b0, 32'hFFFFFFEB);
    drain16();

    // Reset two cycles into the computation.
    @(posedge clk); #1;
    bus16.in_a = 16'h1234; bus16.in_b = 16'h5678; bus16.in_approx = 1'b0; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(bus16.out_valid), 64'd0);
    check("mid_rst_out_prod", 64'(bus16.out_prod), 64'd0);
    check("mid_rst_in_ready", 64'(bus16.in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    send16(16'h0003, 16'h0005, 1'b0, 32'h0000000F);
    drain16();

    // Randomized with random backpressure.
    ready_mode = 1;
    for (int v = 0; v < 40; v++) begin
      ra = 16'($urandom); rb = 16'($urandom); ap = 1'($urandom_range(0, 1));
      if (v % 8 == 0) ra = 16'h8000;
      send16(ra, rb, ap, 32'(model(longint'($signed(ra)), longint'($signed(rb)), ap, 16, 8, 1)));
    end
    drain16();
    ready_mode = 0;

    // 32-bit instance.
    send32(32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000);
    send32(32'h12345678, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFEDCBA988);
    for (int v = 0; v < 12; v++) begin
      wa = $urandom; wb = $urandom; ap = 1'($urandom_range(0, 1));
      send32(wa, wb, ap, model(longint'($signed(wa)), longint'($signed(wb)), ap, 32, 8, 3));
    end
    drain32();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
